vx_mem_ahb_bridge: RTL
======================

Name: vx_mem_ahb_bridge

Overview:
Sits between the Vortex memory port (mem_req_*/mem_rsp_*) and the ahb_manager's bus_protocol_if.
- Accepts one cache-line request at a time.
- Serialises it into BUS_DATA_WIDTH beats on the bus protocol side.
- For reads, reassembles the beats into a line and returns it with the original tag.
- Replaces the combinational glue in the top-level wrapper with a proper single-outstanding-request sequencer.

Parameters:
- MEM_DATA_WIDTH, 512, line width in bits (VX_MEM_DATA_WIDTH).
- MEM_ADDR_WIDTH, 26, line address width (VX_MEM_ADDR_WIDTH).
- MEM_TAG_WIDTH, 8, request tag width (VX_MEM_TAG_WIDTH).
- BUS_DATA_WIDTH, 32, bus beat width in bits.
- BUS_ADDR_WIDTH, 32, bus byte-address width.

Ports:
- VX_clk  in  1  clock.
- VX_reset  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1=write, 0=read.
- mem_req_byteen  in  MEM_DATA_WIDTH/8  write byte enables.
- mem_req_addr  in  MEM_ADDR_WIDTH  line address.
- mem_req_data  in  MEM_DATA_WIDTH  write line.
- mem_req_tag  in  MEM_TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted this cycle.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  MEM_DATA_WIDTH  read line.
- mem_rsp_tag  out  MEM_TAG_WIDTH  tag of the read being returned.
- mem_rsp_ready  in  1  consumer accepts response.
- bus_wen  out  1  bus write request.
- bus_ren  out  1  bus read request.
- bus_addr  out  BUS_ADDR_WIDTH  beat byte address.
- bus_wdata  out  BUS_DATA_WIDTH  beat write data.
- bus_strobe  out  BUS_DATA_WIDTH/8  beat byte strobes.
- bus_rdata  in  BUS_DATA_WIDTH  beat read data.
- bus_request_stall  in  1  beat not yet complete.
- bus_error  in  1  beat error response.
- err_pulse  out  1  one-cycle pulse per errored beat.
- busy  out  1  state != IDLE.

Behaviour:
- Constants: BEATS=MEM_DATA_WIDTH/BUS_DATA_WIDTH (16); LINE_OFF=log2(MEM_DATA_WIDTH/8) (6).
- Reset (VX_reset low, asynchronous): state=IDLE, beat counter=0, data/tag/byteen registers=0. All outputs 0 except mem_req_ready=1. bus_wen/bus_ren drop in the same instant, mid-transfer included; the partial line is discarded and no response is issued.
- States: IDLE, XFER, RSP.
- IDLE:
  - mem_req_ready=1.
  - On mem_req_valid, latch rw, addr, data, byteen and tag; set beat=first enabled beat.
  - Read: beat=0, go to XFER.
  - Write with byteen all zero: no bus traffic, stay in IDLE; the request is consumed.
- XFER:
  - mem_req_ready=0.
  - bus_addr={addr, LINE_OFF'b0} + beat*(BUS_DATA_WIDTH/8), zero-extended to BUS_ADDR_WIDTH.
  - bus_wen=rw, bus_ren=~rw.
  - bus_wdata and bus_strobe carry the beat slice of the latched data and byteen. Read beats drive strobe all ones.
  - A beat completes on a cycle with bus_request_stall=0. Outputs stay stable while stalled.
  - Read completion: capture bus_rdata into slice [beat], or zero if bus_error=1.
  - Write completion: advance to the next beat with a nonzero strobe slice. Beats with zero strobe are skipped and cost no cycles.
  - bus_error=1 on a completing beat: err_pulse=1 for that cycle; the transfer continues.
  - After the last required beat: reads go to RSP; writes go to IDLE. Writes produce no response.
- RSP:
  - mem_rsp_valid=1, mem_rsp_data=assembled line, mem_rsp_tag=latched tag, held stable.
  - mem_rsp_valid and mem_rsp_ready both high: go to IDLE; mem_req_ready rises on the next cycle.
- Single outstanding request; no request/response overlap.
- Latency with zero wait states:
  - Read: accept at cycle 0, beats at cycles 1..16, mem_rsp_valid at cycle 17.
  - Full write: beats at cycles 1..16, mem_req_ready=1 again at cycle 17.
- Counter width: $clog2(BEATS). It never wraps; the terminal beat is detected explicitly.

Decomposition:
- Package vx_mem_ahb_bridge_pkg holds:
  - state enum (IDLE, XFER, RSP);
  - localparams BEATS, LINE_OFF, BEAT_IDX_W;
  - a function beat_strobe(byteen, idx).
- One sub-module, vx_next_beat_sel: combinational priority finder. Given latched byteen and the current index, it returns the next nonzero-strobe beat index and a last flag.

Test Plan:
1. Read, addr=0x000010, tag=0x5A, bus_request_stall always 0, bus_rdata=beat index → bus_addr 0x400, 0x404 … 0x43C on cycles 1..16. mem_rsp_valid at cycle 17 with data word i = i and tag 0x5A.
2. Write with full byteen, data word i = 0xA0+i, 2 stall cycles per beat → each beat held 3 cycles with stable wdata and strobe 0xF. 48 bus cycles total; no mem_rsp_valid.
3. Write with byteen enabling only bytes 4..7 and 60..63 → exactly 2 bus beats, at bus_addr offsets 0x04 and 0x3C, strobe 0xF. Idle again after 2 cycles.
4. Write with byteen all zero → mem_req_ready stays 1, bus_wen never asserted, busy stays 0.
5. Read with bus_error=1 on beat 3 → err_pulse for exactly 1 cycle. Response word 3 = 0, other words correct, response still delivered.
6. mem_rsp_ready held 0 for 5 cycles in RSP → response stable, mem_req_ready=0. Separately, VX_reset asserted mid-XFER at beat 7 → bus_ren=0 immediately; after release state=IDLE, mem_req_ready=1, no response.

Source files
------------

// File: rtl/vx_mem_ahb_bridge_pkg.sv
// vx_mem_ahb_bridge_pkg: shared state type, beat geometry and strobe slicing for the line-to-beat bridge
package vx_mem_ahb_bridge_pkg;
  localparam int LINE_BITS  = 512;
  localparam int BEAT_BITS  = 32;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int STRB_W     = BEAT_BITS / 8;
  localparam int BEATS      = LINE_BITS / BEAT_BITS;
  localparam int LINE_OFF   = $clog2(LINE_BYTES);
  localparam int BEAT_IDX_W = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, XFER, RSP} state_t;
  function automatic logic [STRB_W-1:0] beat_strobe(input logic [LINE_BYTES-1:0] byteen,
                                                    input logic [BEAT_IDX_W-1:0] idx);
    return byteen[idx*STRB_W +: STRB_W];
  endfunction
endpackage

// File: rtl/vx_mem_ahb_bridge_next_beat_sel.sv
// vx_next_beat_sel: lowest beat index at/after idx whose strobe slice is nonzero; last=1 when none remains
module vx_next_beat_sel
  import vx_mem_ahb_bridge_pkg::*;
(
  input  logic [LINE_BYTES-1:0] byteen,
  input  logic [BEAT_IDX_W-1:0] idx,
  input  logic                  incl,
  output logic [BEAT_IDX_W-1:0] nxt,
  output logic                  last
);
  always_comb begin
    nxt  = idx;
    last = 1'b1;
    for (int i = BEATS - 1; i >= 0; i--)
      if ((BEAT_IDX_W'(i) > idx || (incl && BEAT_IDX_W'(i) == idx)) &&
          |beat_strobe(byteen, BEAT_IDX_W'(i))) begin
        nxt  = BEAT_IDX_W'(i);
        last = 1'b0;
      end
  end
endmodule

// File: rtl/vx_mem_ahb_bridge.sv
// vx_mem_ahb_bridge: single-outstanding sequencer serialising cache-line requests into bus beats
module vx_mem_ahb_bridge
  import vx_mem_ahb_bridge_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = LINE_BITS,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int BUS_DATA_WIDTH = BEAT_BITS,
  parameter int BUS_ADDR_WIDTH = 32
) (
  input  logic                          VX_clk,
  input  logic                          VX_reset,
  input  logic                          mem_req_valid,
  input  logic                          mem_req_rw,
  input  logic [MEM_DATA_WIDTH/8-1:0]   mem_req_byteen,
  input  logic [MEM_ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]      mem_req_tag,
  output logic                          mem_req_ready,
  output logic                          mem_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0]     mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]      mem_rsp_tag,
  input  logic                          mem_rsp_ready,
  output logic                          bus_wen,
  output logic                          bus_ren,
  output logic [BUS_ADDR_WIDTH-1:0]     bus_addr,
  output logic [BUS_DATA_WIDTH-1:0]     bus_wdata,
  output logic [BUS_DATA_WIDTH/8-1:0]   bus_strobe,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_rdata,
  input  logic                          bus_request_stall,
  input  logic                          bus_error,
  output logic                          err_pulse,
  output logic                          busy
);
  state_t                      state;
  logic                        rw;
  logic [MEM_ADDR_WIDTH-1:0]   addr;
  logic [MEM_DATA_WIDTH-1:0]   line;
  logic [MEM_DATA_WIDTH/8-1:0] byteen;
  logic [MEM_TAG_WIDTH-1:0]    tag;
  logic [BEAT_IDX_W-1:0]       beat, first_idx, next_idx;
  logic                        first_none, wr_last, last, xfer, done;
  vx_next_beat_sel u_first (
    .byteen(mem_req_byteen), .idx(BEAT_IDX_W'(0)), .incl(1'b1), .nxt(first_idx), .last(first_none)
  );
  vx_next_beat_sel u_next (
    .byteen(byteen), .idx(beat), .incl(1'b0), .nxt(next_idx), .last(wr_last)
  );
  assign xfer          = state == XFER;
  assign done          = xfer & ~bus_request_stall;
  assign last          = rw ? wr_last : beat == BEAT_IDX_W'(BEATS - 1);
  assign mem_req_ready = state == IDLE;
  assign busy          = state != IDLE;
  assign mem_rsp_valid = state == RSP;
  assign mem_rsp_data  = line;
  assign mem_rsp_tag   = tag;
  assign bus_wen       = xfer & rw;
  assign bus_ren       = xfer & ~rw;
  assign bus_addr      = xfer ? BUS_ADDR_WIDTH'({addr, {LINE_OFF{1'b0}}}) +
                                BUS_ADDR_WIDTH'(beat) * BUS_ADDR_WIDTH'(BUS_DATA_WIDTH / 8) : '0;
  assign bus_wdata     = xfer ? line[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;
  assign bus_strobe    = xfer ? (rw ? beat_strobe(byteen, beat) : '1) : '0;
  assign err_pulse     = done & bus_error;
  // the line register holds write data on writes and is overwritten beat by beat on reads
  always_ff @(posedge VX_clk or negedge VX_reset) begin
    if (!VX_reset) begin
      state  <= IDLE;
      rw     <= 1'b0;
      addr   <= '0;
      line   <= '0;
      byteen <= '0;
      tag    <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: if (mem_req_valid) begin
          rw     <= mem_req_rw;
          addr   <= mem_req_addr;
          line   <= mem_req_data;
          byteen <= mem_req_byteen;
          tag    <= mem_req_tag;
          beat   <= mem_req_rw ? first_idx : '0;
          if (!mem_req_rw || !first_none) state <= XFER;
        end
        XFER: if (done) begin
          if (!rw) line[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_error ? '0 : bus_rdata;
          if (last) state <= rw ? IDLE : RSP;
          else beat <= rw ? next_idx : beat + 1'b1;
        end
        RSP: if (mem_rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
